// File: rtl/fft_seq_core.sv
// fft_seq_core
//   Sequential in-place radix-2 DIT FFT/IFFT engine built around a single
//   time-shared butterfly. A frame is loaded in bit-reversed order, then
//   LOG2N*N/2 butterflies run one per cycle, then the bins are streamed out
//   in natural order.
//
// Parameters
//   N  : transform length (power of two, 4..1024)
//   W  : signed input component width
//   TW : signed twiddle width, Q1.(TW-2)
//   OW : internal / output component width = W+LOG2N+1
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset (aborts any frame)
//   i_inverse    0 = forward DFT, 1 = 1/N-scaled inverse; taken with sample 0
//   i_in_valid   input sample valid
//   o_in_ready   engine accepts a sample (high only while loading)
//   i_in_re/im   input sample, signed W bits
//   o_out_valid  output bin valid (high only while unloading)
//   i_out_ready  sink accepts the bin
//   o_out_re/im  output bin, signed OW bits
//   o_out_last   high with bin N-1
//   o_busy       high while computing or unloading
//
// Build option
//   FFT_ROUND_EN : round-half-up at the twiddle shift and at the inverse-mode
//                  >>1; when undefined both points truncate toward -inf.

module fft_seq_core #(
   parameter  int N     = 16,
   parameter  int W     = 16,
   parameter  int TW    = 16,
   localparam int LOG2N = $clog2(N),
   localparam int OW    = W + LOG2N + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_inverse,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic signed [W-1:0]  i_in_re,
   input  logic signed [W-1:0]  i_in_im,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic signed [OW-1:0] o_out_re,
   output logic signed [OW-1:0] o_out_im,
   output logic                 o_out_last,
   output logic                 o_busy
);

   localparam int SW = $clog2(LOG2N + 1);   // stage counter width
   localparam int PW = OW + TW + 2;         // butterfly arithmetic width

   localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (OW - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

`ifdef FFT_ROUND_EN
   localparam logic signed [PW-1:0] TW_RND   = PW'(64'sd1 <<< (TW - 3));
   localparam logic signed [PW-1:0] HALF_RND = PW'(64'sd1);
`else
   localparam logic signed [PW-1:0] TW_RND   = '0;
   localparam logic signed [PW-1:0] HALF_RND = '0;
`endif

   // Twiddle table, evaluated at elaboration: entry i = round(f(2*pi*i/N) * 2^(TW-2)).
   function automatic logic [N/2*TW-1:0] tw_table(input logic is_sin);
      logic [N/2*TW-1:0] t;
      real               a;
      real               scale;
      t     = '0;
      scale = real'(64'sd1 <<< (TW - 2));
      for (int i = 0; i < N / 2; i++) begin
         a = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
         if (is_sin) begin
            t[i*TW +: TW] = TW'(int'($sin(a) * scale));
         end else begin
            t[i*TW +: TW] = TW'(int'($cos(a) * scale));
         end
      end
      return t;
   endfunction

   localparam logic [N/2*TW-1:0] COS_TAB = tw_table(1'b0);
   localparam logic [N/2*TW-1:0] SIN_TAB = tw_table(1'b1);

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   function automatic logic signed [OW-1:0] sat(input logic signed [PW-1:0] v);
      logic signed [OW-1:0] r;
      if (v > SAT_MAX) begin
         r = SAT_MAX[OW-1:0];
      end else if (v < SAT_MIN) begin
         r = SAT_MIN[OW-1:0];
      end else begin
         r = v[OW-1:0];
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LOG2N-1:0]      r_cnt;     // load address counter, reused as unload index
   logic [LOG2N-2:0]      r_b;       // butterfly index within a stage
   logic [SW-1:0]         r_s;       // stage index
   logic                  r_inv;     // mode latched with sample 0
   logic signed [OW-1:0]  r_mem_re [N];
   logic signed [OW-1:0]  r_mem_im [N];

   logic                  w_in_acc;
   logic                  w_out_acc;
   logic                  w_b_last;
   logic                  w_s_last;
   logic [LOG2N-1:0]      w_bx, w_half, w_pos, w_top, w_bot, w_k;
   logic signed [TW-1:0]  w_wr, w_ws, w_wi;
   logic signed [PW-1:0]  w_ar, w_ai, w_br, w_bi, w_wr_x, w_wi_x;
   logic signed [PW-1:0]  w_tr, w_ti, w_sr, w_si, w_dr, w_di;
   logic signed [OW-1:0]  w_top_re, w_top_im, w_bot_re, w_bot_im;

   assign w_in_acc  = (r_state == ST_LOAD) && i_in_valid;
   assign w_out_acc = (r_state == ST_UNLOAD) && i_out_ready;
   assign w_b_last  = (r_b == (LOG2N-1)'(N / 2 - 1));
   assign w_s_last  = (r_s == SW'(LOG2N - 1));

   // Butterfly addressing and twiddle index for (stage r_s, butterfly r_b).
   always_comb begin
      w_bx   = LOG2N'(r_b);
      w_half = LOG2N'(1) << r_s;
      w_pos  = w_bx & (w_half - LOG2N'(1));
      w_top  = ((w_bx >> r_s) << (r_s + SW'(1))) + w_pos;
      w_bot  = w_top + w_half;
      w_k    = w_pos << (SW'(LOG2N - 1) - r_s);
   end

   // Butterfly datapath: t = X[bot]*W^k, then top/bot = sat(X[top] +/- t), halved in inverse mode.
   always_comb begin
      w_wr   = COS_TAB[w_k*TW +: TW];
      w_ws   = SIN_TAB[w_k*TW +: TW];
      // Forward twiddle is cos - j*sin; the inverse uses its conjugate.
      w_wi   = r_inv ? w_ws : -w_ws;
      w_ar   = PW'(r_mem_re[w_top]);
      w_ai   = PW'(r_mem_im[w_top]);
      w_br   = PW'(r_mem_re[w_bot]);
      w_bi   = PW'(r_mem_im[w_bot]);
      w_wr_x = PW'(w_wr);
      w_wi_x = PW'(w_wi);
      w_tr   = (w_br * w_wr_x - w_bi * w_wi_x + TW_RND) >>> (TW - 2);
      w_ti   = (w_br * w_wi_x + w_bi * w_wr_x + TW_RND) >>> (TW - 2);
      w_sr   = w_ar + w_tr;
      w_si   = w_ai + w_ti;
      w_dr   = w_ar - w_tr;
      w_di   = w_ai - w_ti;
      if (r_inv) begin
         w_sr = (w_sr + HALF_RND) >>> 1;
         w_si = (w_si + HALF_RND) >>> 1;
         w_dr = (w_dr + HALF_RND) >>> 1;
         w_di = (w_di + HALF_RND) >>> 1;
      end else begin
         w_sr = w_sr;
         w_si = w_si;
         w_dr = w_dr;
         w_di = w_di;
      end
      w_top_re = sat(w_sr);
      w_top_im = sat(w_si);
      w_bot_re = sat(w_dr);
      w_bot_im = sat(w_di);
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD: begin
            if (w_in_acc && (r_cnt == LOG2N'(N - 1))) begin
               w_state_nxt = ST_COMPUTE;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_COMPUTE: begin
            if (w_b_last && w_s_last) begin
               w_state_nxt = ST_UNLOAD;
            end else begin
               w_state_nxt = ST_COMPUTE;
            end
         end
         ST_UNLOAD: begin
            if (w_out_acc && (r_cnt == LOG2N'(N - 1))) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_UNLOAD;
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // FSM outputs, decoded from registered state and storage.
   always_comb begin
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b0;
      o_out_last  = 1'b0;
      o_out_re    = '0;
      o_out_im    = '0;
      case (r_state)
         ST_LOAD: o_in_ready = 1'b1;
         ST_COMPUTE: o_busy = 1'b1;
         ST_UNLOAD: begin
            o_out_valid = 1'b1;
            o_busy      = 1'b1;
            o_out_re    = r_mem_re[r_cnt];
            o_out_im    = r_mem_im[r_cnt];
            o_out_last  = (r_cnt == LOG2N'(N - 1));
         end
         default: o_in_ready = 1'b0;
      endcase
   end

   // Storage, counters and mode latch. Counters wrap to 0 at the end of each phase.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_b   <= '0;
         r_s   <= '0;
         r_inv <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_mem_re[i] <= '0;
            r_mem_im[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_in_acc) begin
                  r_mem_re[bitrev(r_cnt)] <= OW'(i_in_re);
                  r_mem_im[bitrev(r_cnt)] <= OW'(i_in_im);
                  if (r_cnt == '0) begin
                     r_inv <= i_inverse;
                  end
                  r_cnt <= r_cnt + LOG2N'(1);
               end
            end
            ST_COMPUTE: begin
               r_mem_re[w_top] <= w_top_re;
               r_mem_im[w_top] <= w_top_im;
               r_mem_re[w_bot] <= w_bot_re;
               r_mem_im[w_bot] <= w_bot_im;
               r_b             <= r_b + (LOG2N-1)'(1);
               if (w_b_last && w_s_last) begin
                  r_s <= '0;
               end else if (w_b_last) begin
                  r_s <= r_s + SW'(1);
               end
            end
            ST_UNLOAD: begin
               if (w_out_acc) begin
                  r_cnt <= r_cnt + LOG2N'(1);
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: doc/fft_seq_core.md
# fft_seq_core

Sequential, in-place radix-2 decimation-in-time FFT/IFFT engine with streaming valid/ready input and output ports. It replaces the fully combinational recursive FFT with a single time-shared butterfly, so area scales with N instead of N·log2N. The forward/inverse mode is selected per frame at run time. It sits between a sample source (ADC framer or DMA) and spectral post-processing.

## Interface
- N, 16: transform length; power of two, 4..1024; LOG2N = $clog2(N).
- W, 16: signed input component width (re and im).
- TW, 16: signed twiddle width, format Q1.(TW-2), so +1.0 = 2^(TW-2).
- OW (localparam) = W+LOG2N+1: internal and output component width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- inverse  in  1  mode: 0 = forward DFT, 1 = inverse DFT (1/N scaled); sampled with sample 0.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample.
- in_re, in_im  in  W each  input sample, signed.
- out_valid  out  1  output bin valid.
- out_ready  in  1  sink accepts the bin.
- out_re, out_im  out  OW each  output bin, signed.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE and UNLOAD.

## Operation
- Storage: N-entry complex register array (OW bits per component), reset to 0.
- States:
  - LOAD: in_ready=1. Each in_valid&&in_ready cycle writes the sign-extended sample to address bitrev(cnt), then cnt++. `inverse` is latched on cnt==0. After the N-th accept, go to COMPUTE with s=0, b=0.
  - COMPUTE: one butterfly per cycle, b=0..N/2-1, s=0..LOG2N-1.
    - half=2^s, pos=b&(half-1), top=((b>>s)<<(s+1))+pos, bot=top+half, k=pos<<(LOG2N-1-s).
    - Twiddle is W^k = cos(2πk/N) − j·sin(2πk/N); inverse mode uses the conjugate. The table is a constant function evaluated at elaboration, rounded to nearest.
    - t = X[bot]·W^k. Complex products are full width, then arithmetically shifted right by TW-2.
    - X[top] ← X[top]+t and X[bot] ← X[top]−t.
    - Inverse mode: each sum/difference is also arithmetically shifted right by 1.
    - Every result saturates to OW bits.
    - After b=N/2-1 of s=LOG2N-1, go to UNLOAD.
  - UNLOAD: out_valid=1; out_re/out_im = X[idx] in natural order. idx advances on out_valid&&out_ready. out_last = (idx==N-1). After the last handshake, go to LOAD with cnt=0.
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.
- Reset mid-frame aborts the frame immediately: state=LOAD, counters=0, array cleared.

## Timing
- Reset values: in_ready=1 (LOAD), out_valid=0, out_last=0, busy=0, out_re=out_im=0.
- Load takes N accept cycles; back-pressure comes only from in_ready.
- COMPUTE lasts exactly LOG2N·N/2 cycles. The first out_valid is asserted in the cycle after the last butterfly write. For N=16 that is 33 cycles after the last input accept.
- While out_valid&&!out_ready, out_re, out_im and out_last hold stable.
- in_ready falls in the cycle after the N-th accept. It rises in the cycle after the final output handshake, so LOAD and UNLOAD never overlap.
- Minimum frame period: 2N + LOG2N·N/2 cycles.

## Configuration
- FFT_ROUND_EN defined: round-half-up.
  - Adds 2^(TW-3) before the twiddle shift.
  - In inverse mode, adds 1 before each stage's >>1.
- Undefined: plain truncation (toward −∞) at both points. The rest of the behaviour is identical.

## Test plan
- Forward impulse, N=16: x[0]=1000, all others 0 → all 16 bins = (1000, 0); out_last only on bin 15.
- Forward DC: all x=(100, 0) → X[0]=(1600, 0), all other bins (0, 0) ±1 LSB.
- Forward shifted impulse: x[1]=(1000, 0) → X[k]=1000·W^k, e.g. X[4]=(0, −1000) and X[2]=(707, −707), each ±1 LSB.
- Inverse: X[0]=(1600, 0), others 0, inverse=1 → all outputs (100, 0). Then a forward→inverse round trip of a random frame recovers the input within ±LOG2N LSB.
- Back-pressure: out_ready toggled on a random pattern → each bin is transferred exactly once, in order, and held stable while stalled. in_valid pulses during COMPUTE are not accepted.
- Reset during COMPUTE (rst_n low for one cycle at butterfly 20) → next cycle in_ready=1, out_valid=0, busy=0. The following impulse frame then gives the correct result.
